// File: rtl/lock_entry_ctrl_if.sv
// Pin bundle between the lock I/O mapping and lock_entry_ctrl.
// The controller uses the slave modport; the driving side uses master.
interface lock_entry_ctrl_if #(
    parameter int CODE_LEN = 4
);
    logic [3:0]            in_digit;
    logic                  enter_btn;
    logic [4*CODE_LEN-1:0] code_word;
    logic                  locked_led;
    logic                  unlocked_led;
    logic                  error_led;
    logic [2:0]            state_leds;
    logic [2:0]            tries_left;

    modport master (
        output in_digit, enter_btn, code_word,
        input  locked_led, unlocked_led, error_led, state_leds, tries_left
    );

    modport slave (
        input  in_digit, enter_btn, code_word,
        output locked_led, unlocked_led, error_led, state_leds, tries_left
    );
endinterface

// File: rtl/lock_entry_ctrl.sv
// Multi-digit code entry with attempt limit and lockout for the digital lock.
// Optional feature: define LOCK_RELOCK_TIMER_EN to relock OPEN after UNLOCK_CYCLES.
module lock_entry_ctrl #(
    parameter int CODE_LEN       = 4,
    parameter int MAX_TRIES      = 3,
    parameter int ERR_CYCLES     = 4,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int UNLOCK_CYCLES  = 5000
) (
    input  logic              clk,
    input  logic              reset,
    lock_entry_ctrl_if.slave  bus
);
    localparam int EW   = 4 * CODE_LEN;
    localparam int TMAX = (ERR_CYCLES > LOCKOUT_CYCLES) ? ERR_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
`ifdef LOCK_RELOCK_TIMER_EN
    localparam int RW   = $clog2(UNLOCK_CYCLES + 1);
`endif

    typedef enum logic [2:0] {
        ST_LOCKED  = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_ERROR   = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic            enter_q, enter_d;
    logic [EW-1:0]   entry_q, entry_d;
    logic [3:0]      digit_cnt_q, digit_cnt_d;
    logic [2:0]      tries_q, tries_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            locked_q, locked_d;
    logic            unlocked_q, unlocked_d;
    logic            error_q, error_d;
`ifdef LOCK_RELOCK_TIMER_EN
    logic [RW-1:0]   rlk_q, rlk_d;
`endif

    logic            press;
    logic [EW-1:0]   entry_shift;

    assign press       = bus.enter_btn & ~enter_q;
    // Newest digit enters at the LS nibble, so the first digit ends up MS.
    assign entry_shift = (entry_q << 4) | EW'(bus.in_digit);

    always_comb begin
        state_d     = state_q;
        enter_d     = bus.enter_btn;
        entry_d     = entry_q;
        digit_cnt_d = digit_cnt_q;
        tries_d     = tries_q;
        tmr_d       = tmr_q;
`ifdef LOCK_RELOCK_TIMER_EN
        rlk_d       = rlk_q;
`endif
        case (state_q)
            ST_LOCKED: begin
                if (press) begin
                    entry_d     = entry_shift;
                    digit_cnt_d = 4'd1;
                    state_d     = (CODE_LEN == 1) ? ST_CHECK : ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (press) begin
                    entry_d     = entry_shift;
                    digit_cnt_d = digit_cnt_q + 4'd1;
                    if (digit_cnt_q + 4'd1 == 4'(CODE_LEN))
                        state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                digit_cnt_d = 4'd0;
                tmr_d       = '0;
                if (entry_q == bus.code_word) begin
                    state_d = ST_OPEN;
                    tries_d = 3'(MAX_TRIES);
`ifdef LOCK_RELOCK_TIMER_EN
                    rlk_d   = '0;
`endif
                end else begin
                    // tries_q is never 0 here: LOCKOUT always reloads it.
                    tries_d = tries_q - 3'd1;
                    state_d = (tries_q == 3'd1) ? ST_LOCKOUT : ST_ERROR;
                end
            end
            ST_OPEN: begin
`ifdef LOCK_RELOCK_TIMER_EN
                if (press || rlk_q == RW'(UNLOCK_CYCLES - 1)) begin
                    state_d = ST_LOCKED;
                    rlk_d   = '0;
                end else begin
                    rlk_d   = rlk_q + 1'b1;
                end
`else
                if (press)
                    state_d = ST_LOCKED;
`endif
            end
            ST_ERROR: begin
                if (tmr_q == TW'(ERR_CYCLES - 1)) begin
                    state_d = ST_LOCKED;
                    tmr_d   = '0;
                end else begin
                    tmr_d   = tmr_q + 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_q == TW'(LOCKOUT_CYCLES - 1)) begin
                    state_d = ST_LOCKED;
                    tmr_d   = '0;
                    tries_d = 3'(MAX_TRIES);
                end else begin
                    tmr_d   = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d     = ST_LOCKED;
                digit_cnt_d = 4'd0;
                tmr_d       = '0;
            end
        endcase

        locked_d   = (state_d != ST_OPEN);
        unlocked_d = (state_d == ST_OPEN);
        error_d    = (state_d == ST_ERROR) || (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LOCKED;
            enter_q     <= 1'b1;
            entry_q     <= '0;
            digit_cnt_q <= 4'd0;
            tries_q     <= 3'(MAX_TRIES);
            tmr_q       <= '0;
            locked_q    <= 1'b1;
            unlocked_q  <= 1'b0;
            error_q     <= 1'b0;
`ifdef LOCK_RELOCK_TIMER_EN
            rlk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            enter_q     <= enter_d;
            entry_q     <= entry_d;
            digit_cnt_q <= digit_cnt_d;
            tries_q     <= tries_d;
            tmr_q       <= tmr_d;
            locked_q    <= locked_d;
            unlocked_q  <= unlocked_d;
            error_q     <= error_d;
`ifdef LOCK_RELOCK_TIMER_EN
            rlk_q       <= rlk_d;
`endif
        end
    end

    assign bus.state_leds   = state_q;
    assign bus.tries_left   = tries_q;
    assign bus.locked_led   = locked_q;
    assign bus.unlocked_led = unlocked_q;
    assign bus.error_led    = error_q;
endmodule

// File: doc/lock_entry_ctrl.md
# lock_entry_ctrl

Sequencing controller for the digital lock datapath. It edge-detects the enter button and assembles a multi-digit code one nibble at a time, then compares the code against a stored code word. It tracks failed attempts, enforces a lockout period after too many failures, and drives the lock status LEDs and the 3-bit state display. It sits between the `io_in` pin mapping and the LED outputs in the lock top level, replacing single-digit checking with attempt-limited multi-digit entry.

## Interface
Parameters:
- `CODE_LEN`, 4: digits per code; valid range 1–8.
- `MAX_TRIES`, 3: failed attempts allowed before lockout; valid range 1–7.
- `ERR_CYCLES`, 4: cycles the ERROR state is held; must be ≥ 1.
- `LOCKOUT_CYCLES`, 1000: cycles the LOCKOUT state is held; must be ≥ 1.
- `UNLOCK_CYCLES`, 5000: auto-relock timeout; used only with `LOCK_RELOCK_TIMER_EN`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_digit`  in  4  digit value, sampled on an enter press.
- `enter_btn`  in  1  enter button, level input, already synchronized.
- `code_word`  in  4*CODE_LEN  stored code; the first digit entered is the MS nibble.
- `locked_led`  out  1  high in every state except OPEN.
- `unlocked_led`  out  1  high only in OPEN.
- `error_led`  out  1  high in ERROR and LOCKOUT.
- `state_leds`  out  3  current state encoding.
- `tries_left`  out  3  remaining attempts.

## Operation
- Press detection: `enter_q` is registered `enter_btn`. `press = enter_btn & ~enter_q`.
  - One press per rising edge; a held button gives exactly one press.
  - `enter_q` resets to 1, so a button held through reset produces no press.
- State encoding (`state_leds`): LOCKED=0, ENTRY=1, CHECK=2, OPEN=3, ERROR=4, LOCKOUT=5. Values 6–7 are unreachable; if entered, go to LOCKED.
- LOCKED: on a press, shift `in_digit` into the entry register and set `digit_cnt`=1. Go to ENTRY, or to CHECK if `CODE_LEN`=1.
- ENTRY: each press shifts in a digit and increments `digit_cnt`. When `digit_cnt` reaches `CODE_LEN`, go to CHECK.
- CHECK: lasts exactly one cycle. Compare the entry register against `code_word`, sampled this cycle.
  - Match: go to OPEN; reload `tries_left`=`MAX_TRIES`.
  - Mismatch: decrement `tries_left`. If the new value is 0, go to LOCKOUT; otherwise go to ERROR.
  - Clear `digit_cnt` in both cases.
- ERROR: hold for `ERR_CYCLES` cycles, then go to LOCKED. Presses are ignored.
- LOCKOUT: hold for `LOCKOUT_CYCLES` cycles, then reload `tries_left`=`MAX_TRIES` and go to LOCKED. Presses are ignored.
- OPEN: a press returns to LOCKED; that press is not captured as a digit.
- All nibble values 0–15 are accepted as digits; there is no validation.
- `code_word` changing mid-entry has no effect until CHECK.
- A press in CHECK is ignored.

## Timing
- Reset values: state LOCKED, `locked_led`=1, `unlocked_led`=0, `error_led`=0, `state_leds`=0, `tries_left`=`MAX_TRIES`, `digit_cnt`=0, entry register 0, timers 0, `enter_q`=1.
- Reset mid-operation (including during ERROR or LOCKOUT) returns to the reset values on the next edge and aborts any pending entry.
- All outputs are registered or decoded directly from registered state; there are no combinational paths from inputs to outputs.
- Timing of the final press:
  - `enter_btn` rises and is sampled at edge N; the last digit is captured at edge N, and the state is CHECK during cycle N+1.
  - The decision is registered at edge N+1; OPEN, ERROR or LOCKOUT is visible after edge N+1.
- ERROR lasts exactly `ERR_CYCLES` cycles; LOCKOUT lasts exactly `LOCKOUT_CYCLES` cycles.
- Timers are wide enough for the largest parameter value, and there is no wrap-around.
- `tries_left` is decremented at the same edge that leaves CHECK.

## Configuration
- `LOCK_RELOCK_TIMER_EN` defined:
  - OPEN starts a counter on entry and returns to LOCKED after `UNLOCK_CYCLES` cycles, or earlier on a press.
  - If a press and the timeout occur in the same cycle, the result is LOCKED; both causes agree.
- `LOCK_RELOCK_TIMER_EN` undefined:
  - OPEN is held indefinitely until a press or reset.
  - The relock counter logic is absent.

## Test plan
Bench parameters: `CODE_LEN`=4, `code_word`=16'h1234, `MAX_TRIES`=3, `ERR_CYCLES`=4, `LOCKOUT_CYCLES`=20, `UNLOCK_CYCLES`=10.

- Correct code: press 1,2,3,4, each press 1 cycle high with ≥1 low cycle between presses → `state_leds`=2 for one cycle, then 3. `unlocked_led`=1, `locked_led`=0, `tries_left`=3.
- Wrong code: enter 1,2,3,5 → CHECK, then ERROR (`error_led`=1, `state_leds`=4) for exactly 4 cycles, then LOCKED with `tries_left`=2.
- Lockout: three wrong codes → third CHECK goes to LOCKOUT (`state_leds`=5, `tries_left`=0). Presses are ignored for 20 cycles, then LOCKED with `tries_left`=3.
- Held button and reset:
  - Hold `enter_btn` high for 10 cycles → exactly one digit captured, `state_leds`=1.
  - Assert `reset` for 1 cycle during entry → state 0 and entry cleared.
  - A button held through reset release captures nothing.
- Relock:
  - With `LOCK_RELOCK_TIMER_EN` defined: after OPEN, no press → LOCKED exactly 10 cycles later.
  - With `LOCK_RELOCK_TIMER_EN` undefined: OPEN is still held after 100 cycles; one press → LOCKED.
- Reset during LOCKOUT → next cycle `state_leds`=0, `tries_left`=3. Then entering 1,2,3,4 opens the lock.
